mdu_ctrl: RTL



---
 rtl/mdu_pkg.sv | 39 +++
 rtl/mdu_arith.sv | 69 ++++++
 rtl/mdu_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared opcode constants, FSM encoding and op-class helpers for the multiply/divide unit.
// Build option: define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bit n set means opcode n occupies the unit for several cycles.
`ifdef MDU_MADD_EN
  localparam logic [15:0] LONG_OP_MASK = 16'h1E1E;
`else
  localparam logic [15:0] LONG_OP_MASK = 16'h001E;
`endif

  function automatic logic is_long_op(input logic [3:0] op);
    return LONG_OP_MASK[op];
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for multiply, divide and (optionally) accumulate ops.
// Build option: MDU_MADD_EN adds the HI:LO accumulate/subtract path.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi_out,
  input  logic [31:0] lo_out,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        rt_safe;
  logic [31:0]        abs_rs;
  logic [31:0]        abs_rt;
  logic [31:0]        mag_quot;
  logic [31:0]        mag_rem;
  logic [31:0]        quot_s;
  logic [31:0]        rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // A zero divisor is swapped for 1 so the dividers never see it; the flag suppresses commit.
  assign div_by_zero = is_div_op(op) && (rt_val == 32'd0);
  assign rt_safe     = (rt_val == 32'd0) ? 32'd1 : rt_val;

  // Signed divide via magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign abs_rs   = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
  assign abs_rt   = rt_safe[31] ? (~rt_safe + 32'd1) : rt_safe;
  assign mag_quot = abs_rs / abs_rt;
  assign mag_rem  = abs_rs % abs_rt;
  assign quot_s   = (rs_val[31] ^ rt_safe[31]) ? (~mag_quot + 32'd1) : mag_quot;
  assign rem_s    = rs_val[31] ? (~mag_rem + 32'd1) : mag_rem;
  assign quot_u   = rs_val / rt_safe;
  assign rem_u    = rs_val % rt_safe;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi_out, lo_out};
`else
  logic unused_acc;
  assign unused_acc = ^{hi_out, lo_out};
`endif

  always_comb begin
    result = 64'd0;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {rem_s, quot_s};
      OP_DIVU:  result = {rem_u, quot_u};
`ifdef MDU_MADD_EN
      OP_MADD:  result = acc + prod_s;
      OP_MADDU: result = acc + prod_u;
      OP_MSUB:  result = acc - prod_s;
      OP_MSUBU: result = acc - prod_u;
`endif
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO registers and busy flag.
// Build option: MDU_MADD_EN (accumulate ops, handled through mdu_pkg and mdu_arith).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [3:0] MULT_CNT = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_CNT  = DIV_CYCLES[3:0];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_dz_q, pend_dz_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] arith_result;
  logic        arith_dz;

  mdu_arith u_arith (
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .hi_out      (hi_q),
    .lo_out      (lo_q),
    .result      (arith_result),
    .div_by_zero (arith_dz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pend_q    <= 64'd0;
      pend_dz_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_dz_q <= pend_dz_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_dz_d = pend_dz_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_long_op(op)) begin
            pend_d    = arith_result;
            pend_dz_d = arith_dz;
            cnt_d     = is_div_op(op) ? DIV_CNT : MULT_CNT;
            busy_d    = 1'b1;
            state_d   = ST_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here; the hazard unit should never issue it.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
          if (!pend_dz_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy   = busy_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
